// File: rtl/reg_share_arb.sv
// reg_share_arb: two-requester front end for a shared WIDTH-bit storage register.
//
// Each requester runs a 4-phase req/ack handshake. A round-robin arbiter picks the
// owner in IDLE, the owner's data is loaded on the edge leaving GRANT, ack pulses for
// one cycle in ACK, and REL waits for the owner to drop req before returning to IDLE.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req0, wdata0    requester 0 write request and data
//   req1, wdata1    requester 1 write request and data
//   q               shared register contents
//   gnt0, gnt1      grant to requester 0 / 1 (GRANT, ACK, REL; owner only)
//   ack0, ack1      one-cycle write-committed pulse (ACK state, owner only)
//   busy            high in every state except IDLE
//   wcnt            wrapping count of completed writes
module reg_share_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic [WIDTH-1:0] q,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [7:0]       wcnt
);

    typedef enum logic [1:0] {StIdle, StGrant, StAck, StRel} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;  // 0: requester 0 owns the transaction
    logic             last_q, last_d;    // requester served most recently
    logic [WIDTH-1:0] q_q, q_d;
    logic [7:0]       wcnt_q, wcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // so requester 0 wins the first tie
            q_q     <= '0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            q_q     <= q_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        q_d     = q_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StGrant;
                    // On a tie the requester not served last wins.
                    if (req0 && req1) owner_d = ~last_q;
                    else              owner_d = req1;
                end
            end
            StGrant: begin
                // Leaving GRANT: commit the write and note who was served.
                state_d = StAck;
                q_d     = owner_q ? wdata1 : wdata0;
                wcnt_d  = wcnt_q + 8'd1;
                last_d  = owner_q;
            end
            StAck: begin
                state_d = StRel;
            end
            StRel: begin
                // Stay until the owner's req is seen low so one handshake writes once.
                if (!(owner_q ? req1 : req0)) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign gnt0 = busy & ~owner_q;
    assign gnt1 = busy & owner_q;
    assign ack0 = (state_q == StAck) & ~owner_q;
    assign ack1 = (state_q == StAck) & owner_q;
    assign q    = q_q;
    assign wcnt = wcnt_q;

endmodule

// File: tb/tb_reg_share_arb.sv
module tb_reg_share_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] wd[2];
    logic [7:0] q;
    logic [7:0] wcnt;
    logic       gnt0, gnt1, ack0, ack1, busy;

    int n_checks = 0;
    int n_pass   = 0;

    reg_share_arb #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req[0]),
        .wdata0 (wd[0]),
        .req1   (req[1]),
        .wdata1 (wd[1]),
        .q      (q),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .busy   (busy),
        .wcnt   (wcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a transaction is either absent or active with an age in
    // cycles since it was granted. Age 0 = granted, age 1 = acknowledged, age >= 2 =
    // waiting for the owner to release.
    bit         m_active;
    int         m_age;
    int         m_owner;
    int         m_last;
    logic [7:0] m_q;
    logic [7:0] m_wcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_age    = 0;
            m_owner  = 0;
            m_last   = 1;
            m_q      = 8'h00;
            m_wcnt   = 8'h00;
        end else if (!m_active) begin
            if (req[0] || req[1]) begin
                m_active = 1;
                m_age    = 0;
                if (req[0] && req[1]) m_owner = 1 - m_last;
                else                  m_owner = req[1] ? 1 : 0;
            end
        end else begin
            if (m_age == 0) begin
                m_q    = wd[m_owner];
                m_wcnt = m_wcnt + 8'd1;
                m_last = m_owner;
            end else if (m_age >= 2 && !req[m_owner]) begin
                m_active = 0;
            end
            m_age++;
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic e_g0, e_g1, e_a0, e_a1;
        e_g0 = m_active && m_owner == 0;
        e_g1 = m_active && m_owner == 1;
        e_a0 = e_g0 && m_age == 1;
        e_a1 = e_g1 && m_age == 1;
        n_checks++;
        if (q !== m_q || wcnt !== m_wcnt || busy !== m_active || gnt0 !== e_g0 ||
            gnt1 !== e_g1 || ack0 !== e_a0 || ack1 !== e_a1) begin
            $display("FAIL model_cmp t=%0t got q=%h wcnt=%h busy=%b gnt=%b%b ack=%b%b expected q=%h wcnt=%h busy=%b gnt=%b%b ack=%b%b",
                     $time, q, wcnt, busy, gnt1, gnt0, ack1, ack0,
                     m_q, m_wcnt, m_active, e_g1, e_g0, e_a1, e_a0);
        end else begin
            n_pass++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req   = 2'b00;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Full handshake; returns with the FSM back in IDLE.
    task automatic do_write(input int who, input logic [7:0] d);
        bit seen;
        logic [1:0] acks;
        seen     = 0;
        wd[who]  = d;
        req[who] = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            acks = {ack1, ack0};
            if (acks[who]) seen = 1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        req[who] = 1'b0;
        tick();
        tick();
    endtask

    int         ag[2];
    int         hold[2];
    logic [1:0] acks, gnts;

    initial begin
        req   = 2'b00;
        wd[0] = 8'h00;
        wd[1] = 8'h00;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #11;
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_ack", 32'({ack1, ack0}), 32'd0);
        check("rst_wcnt", 32'(wcnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0.
        wd[0]  = 8'h3C;
        req[0] = 1'b1;
        tick();
        check("sw_gnt0", 32'(gnt0), 32'd1);
        check("sw_ack0_early", 32'(ack0), 32'd0);
        tick();
        check("sw_q", 32'(q), 32'h3C);
        check("sw_ack0", 32'(ack0), 32'd1);
        check("sw_wcnt", 32'(wcnt), 32'd1);
        tick();
        check("sw_ack0_once", 32'(ack0), 32'd0);
        check("sw_busy_rel", 32'(busy), 32'd1);
        req[0] = 1'b0;
        tick();
        check("sw_busy_drop", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of GRANT.
        wd[0]  = 8'hA5;
        req[0] = 1'b1;
        tick();
        check("mr_gnt0", 32'(gnt0), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_q", 32'(q), 32'h00);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("mr_ack", 32'({ack1, ack0}), 32'd0);
        check("mr_wcnt", 32'(wcnt), 32'd0);
        req[0] = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        check("mr_no_write_q", 32'(q), 32'h00);
        check("mr_no_write_wcnt", 32'(wcnt), 32'd0);

        // Tie after reset: requester 0 first, then requester 1.
        wd[0] = 8'h11;
        wd[1] = 8'h22;
        req   = 2'b11;
        tick();
        check("tie_gnt", 32'({gnt1, gnt0}), 32'b01);
        tick();
        check("tie_q0", 32'(q), 32'h11);
        check("tie_ack0", 32'(ack0), 32'd1);
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        check("tie_gnt1", 32'({gnt1, gnt0}), 32'b10);
        tick();
        check("tie_q1", 32'(q), 32'h22);
        check("tie_ack1", 32'(ack1), 32'd1);
        req[1] = 1'b0;
        tick();
        tick();

        // Requester 0 served last, so the next tie goes to requester 1.
        do_write(0, 8'h5F);
        wd[0] = 8'h33;
        wd[1] = 8'h44;
        req   = 2'b11;
        tick();
        check("tie2_gnt", 32'({gnt1, gnt0}), 32'b10);
        tick();
        check("tie2_q", 32'(q), 32'h44);
        req = 2'b00;
        tick();
        tick();

        // Held request: one write only, FSM parked in REL.
        do_reset();
        wd[0]  = 8'h77;
        req[0] = 1'b1;
        tick();
        tick();
        check("held_ack0", 32'(ack0), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_no_ack", 32'(ack0), 32'd0);
            check("held_busy", 32'(busy), 32'd1);
        end
        check("held_wcnt", 32'(wcnt), 32'd1);
        req[0] = 1'b0;
        tick();
        check("held_release", 32'(busy), 32'd0);

        // Non-owner request arriving during requester 0's GRANT.
        wd[0]  = 8'h66;
        req[0] = 1'b1;
        tick();
        wd[1]  = 8'h5A;
        req[1] = 1'b1;
        check("no_gnt1_grant", 32'(gnt1), 32'd0);
        tick();
        check("no_gnt1_ack", 32'(gnt1), 32'd0);
        check("no_q0", 32'(q), 32'h66);
        tick();
        tick();
        check("no_gnt1_rel", 32'(gnt1), 32'd0);
        req[0] = 1'b0;
        tick();
        check("no_idle", 32'({busy, gnt1}), 32'b00);
        tick();
        check("no_gnt1", 32'(gnt1), 32'd1);
        tick();
        check("no_q1", 32'(q), 32'h5A);
        check("no_ack1", 32'(ack1), 32'd1);
        req[1] = 1'b0;
        tick();
        tick();

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 255; i++) do_write(i % 2, 8'(i));
        check("wrap_255", 32'(wcnt), 32'd255);
        do_write(0, 8'hEE);
        check("wrap_0", 32'(wcnt), 32'd0);
        check("wrap_q", 32'(q), 32'hEE);

        // Randomized traffic from two well-behaved agents with occasional early drops.
        ag[0] = 0;
        ag[1] = 0;
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            acks = {ack1, ack0};
            gnts = {gnt1, gnt0};
            for (int n = 0; n < 2; n++) begin
                case (ag[n])
                    0: if ($urandom % 3 == 0) begin
                        wd[n]  = 8'($urandom);
                        req[n] = 1'b1;
                        ag[n]  = 1;
                    end
                    1: if (acks[n]) begin
                        hold[n] = int'($urandom % 4);
                        ag[n]   = 2;
                    end else if (gnts[n] && $urandom % 16 == 0) begin
                        req[n] = 1'b0;
                        ag[n]  = 0;
                    end
                    default: if (hold[n] == 0) begin
                        req[n] = 1'b0;
                        ag[n]  = 0;
                    end else begin
                        hold[n]--;
                    end
                endcase
            end
            tick();
        end
        req = 2'b00;
        tick();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Shares a single WIDTH-bit storage register between two requesters. Each requester uses a 4-phase req/ack handshake. A round-robin arbiter with a small FSM controls access. The block sits in front of the lab's reset-able D flip-flop storage: it decides whose data is loaded, when, and reports completion. It also keeps a wrapping count of completed writes for debug.

## Interface
- WIDTH, 8, width of the shared register and of both write-data buses
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- req0  in  1  requester 0 write request; held high until ack0 is seen
- wdata0  in  WIDTH  requester 0 data; stable while req0 is high
- req1  in  1  requester 1 write request; same rules as req0
- wdata1  in  WIDTH  requester 1 data
- q  out  WIDTH  shared register contents
- gnt0  out  1  requester 0 currently granted
- gnt1  out  1  requester 1 currently granted
- ack0  out  1  one-cycle pulse: requester 0 write committed
- ack1  out  1  one-cycle pulse: requester 1 write committed
- busy  out  1  high in every state except IDLE
- wcnt  out  8  completed-write counter

## Operation
- States and transitions:
  - IDLE: go to GRANT when req0 or req1 is high.
  - GRANT: go to ACK unconditionally.
  - ACK: go to REL unconditionally.
  - REL: go to IDLE when the granted req is low; otherwise stay.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins (round-robin).
  - The winner is held in a registered grant-owner bit for the whole transaction.
  - A last-served flop updates when entering ACK. It resets to "requester 1", so requester 0 wins the first tie.
- gnt0/gnt1 are high in GRANT, ACK and REL for the owner only. They are never both high.
- Write: on the clock edge leaving GRANT, q takes the owner's wdata. No other path changes q except reset.
- Acknowledge:
  - ackN is high exactly in the ACK state for owner N.
  - wcnt increments by 1 on the same edge that enters ACK.
  - wcnt is 8-bit modulo and wraps 255 -> 0.
- Non-owner request: ignored during GRANT, ACK and REL. It stays pending and is arbitrated in the next IDLE.
- Owner dropping req early (during GRANT or ACK): protocol violation, but well-defined. The write still commits, ack still pulses, and REL exits on the first cycle req is seen low.
- Owner holding req across REL: the block stays in REL, so one handshake never produces a second write.

## Timing
- Reset values: q = 0, gnt0 = gnt1 = 0, ack0 = ack1 = 0, busy = 0, wcnt = 0, state IDLE, last-served = 1.
- Reset mid-operation: all of the above take effect immediately (asynchronous). An in-flight write that has not reached the GRANT-exit edge is lost.
- Latency, with req sampled high at edge E0 (IDLE -> GRANT):
  - gnt high after E0.
  - q updated and ack high after E1.
  - REL entered after E2.
  - IDLE is reached at the first edge where req is sampled low, earliest E3.
- Best-case throughput: one write per 4 cycles, i.e. req low for one cycle after the ack and back high.
- Back-to-back with both requesting: if req1 is held throughout and req0 drops after ack0, the next IDLE grants requester 1. Grants then alternate as long as both keep requesting.
- All outputs are registered or decoded from state. No combinational path from req or wdata to any output.

## Test plan
- Reset: assert rst_n = 0 mid-GRANT with wdata0 = 0xA5 -> q = 0, gnt/ack = 0, busy = 0, wcnt = 0 immediately without waiting for a clock edge. After release, no write occurs.
- Single write: req0 = 1, wdata0 = 0x3C from cycle 0 -> gnt0 in cycle 1, q = 0x3C and ack0 = 1 for exactly one cycle in cycle 2, wcnt = 1. busy drops one cycle after req0 falls.
- Tie and round-robin: after reset, req0 and req1 are raised together with 0x11 and 0x22 -> requester 0 is served first (q = 0x11), then requester 1 (q = 0x22). Repeating the tie with last-served = 0 grants requester 1 first.
- Held request: keep req0 high for 10 cycles after ack0 -> exactly one write, wcnt += 1, FSM stays in REL, ack0 is not repeated.
- Non-owner during transaction: raise req1 during requester 0's GRANT -> gnt1 stays 0 until requester 0's REL exits. Requester 1 is then served with its data.
- Counter wrap: perform 256 writes -> wcnt goes 255 -> 0. q holds the last written value.
